// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the slave's FSM state encodings.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_WAIT_AW = 2'd1,
    W_WAIT_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi4_lite_ram_mem.sv
// Byte-enabled word array: one synchronous strobed write port and one registered read port.
module axi4_lite_ram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_idx,
  input  logic                    rd_zero,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Strobed write; the array is never reset so contents survive iRST.
  always_ff @(posedge iCLK) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wr_strb[b]) begin
          mem_r[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read register: old data is returned when a write to the same word lands on the same edge.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= rd_zero ? {DATA_WIDTH{1'b0}} : mem_r[rd_idx];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/axi4_lite_ram_slave.sv
// AXI4-Lite RAM slave with independent write and read FSMs over axi4_lite_ram_mem.
// Define AXI4_LITE_RAM_ERR_EN to return SLVERR for addresses outside the RAM window.
module axi4_lite_ram_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    s_AWVALID,
  output logic                    s_AWREADY,
  input  logic [ADDR_WIDTH-1:0]   s_AWADDR,
  input  logic [2:0]              s_AWPROT,
  input  logic                    s_WVALID,
  output logic                    s_WREADY,
  input  logic [DATA_WIDTH-1:0]   s_WDATA,
  input  logic [DATA_WIDTH/8-1:0] s_WSTRB,
  output logic                    s_BVALID,
  input  logic                    s_BREADY,
  output logic [1:0]              s_BRESP,
  input  logic                    s_ARVALID,
  output logic                    s_ARREADY,
  input  logic [ADDR_WIDTH-1:0]   s_ARADDR,
  input  logic [2:0]              s_ARPROT,
  output logic                    s_RVALID,
  input  logic                    s_RREADY,
  output logic [DATA_WIDTH-1:0]   s_RDATA,
  output logic [1:0]              s_RRESP
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  // Bits [1:0] drop out in the shift; out-of-window words wrap modulo MEM_DEPTH.
  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word_s;
    word_s = (addr - BASE_ADDR) >> 2'd2;
    return IDX_W'(word_s % DEPTH_A);
  endfunction

  w_state_t w_state_r, w_next_s;
  r_state_t r_state_r, r_next_s;

  logic                  awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
  logic [1:0]            bresp_r, rresp_r;
  logic [ADDR_WIDTH-1:0] awaddr_r, wr_addr_s;
  logic [DATA_WIDTH-1:0] wdata_r, wr_data_s, rd_data_s;
  logic [STRB_W-1:0]     wstrb_r, wr_strb_s;
  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic                  wr_err_s, rd_err_s;
  logic                  prot_unused_s;

  assign prot_unused_s = ^{s_AWPROT, s_ARPROT};

  // Handshakes are masked while reset is asserted so nothing commits during reset.
  assign aw_hs_s = s_AWVALID && awready_r && iRST;
  assign w_hs_s  = s_WVALID && wready_r && iRST;
  assign ar_hs_s = s_ARVALID && arready_r && iRST;

  assign wr_addr_s = aw_hs_s ? s_AWADDR : awaddr_r;
  assign wr_data_s = w_hs_s ? s_WDATA : wdata_r;
  assign wr_strb_s = w_hs_s ? s_WSTRB : wstrb_r;

`ifdef AXI4_LITE_RAM_ERR_EN
  localparam logic [ADDR_WIDTH:0] END_A = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < {1'b0, BASE_ADDR}) || ({1'b0, addr} >= END_A);
  endfunction

  assign wr_err_s = addr_err(wr_addr_s);
  assign rd_err_s = addr_err(s_ARADDR);
`else
  assign wr_err_s = 1'b0;
  assign rd_err_s = 1'b0;
`endif

  // Write next-state; commit_s marks the edge on which the last of AW/W is accepted.
  always_comb begin
    w_next_s = w_state_r;
    commit_s = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          w_next_s = W_RESP;
          commit_s = 1'b1;
        end else if (aw_hs_s) begin
          w_next_s = W_WAIT_W;
        end else if (w_hs_s) begin
          w_next_s = W_WAIT_AW;
        end else begin
          w_next_s = W_IDLE;
        end
      end
      W_WAIT_W: begin
        if (w_hs_s) begin
          w_next_s = W_RESP;
          commit_s = 1'b1;
        end else begin
          w_next_s = W_WAIT_W;
        end
      end
      W_WAIT_AW: begin
        if (aw_hs_s) begin
          w_next_s = W_RESP;
          commit_s = 1'b1;
        end else begin
          w_next_s = W_WAIT_AW;
        end
      end
      W_RESP: begin
        if (s_BREADY) begin
          w_next_s = W_IDLE;
        end else begin
          w_next_s = W_RESP;
        end
      end
      default: begin
        w_next_s = W_IDLE;
      end
    endcase
  end

  // Write state plus registered AW/W/B outputs decoded from the next state.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b1;
      wready_r  <= 1'b1;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      w_state_r <= w_next_s;
      awready_r <= (w_next_s == W_IDLE) || (w_next_s == W_WAIT_AW);
      wready_r  <= (w_next_s == W_IDLE) || (w_next_s == W_WAIT_W);
      bvalid_r  <= (w_next_s == W_RESP);
      if (commit_s) begin
        bresp_r <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Hold whichever half of the write arrived first.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      awaddr_r <= {ADDR_WIDTH{1'b0}};
      wdata_r  <= {DATA_WIDTH{1'b0}};
      wstrb_r  <= {STRB_W{1'b0}};
    end else begin
      if (aw_hs_s) begin
        awaddr_r <= s_AWADDR;
      end
      if (w_hs_s) begin
        wdata_r <= s_WDATA;
        wstrb_r <= s_WSTRB;
      end
    end
  end

  // Read next-state.
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_next_s = R_DATA;
        end else begin
          r_next_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (s_RREADY) begin
          r_next_s = R_IDLE;
        end else begin
          r_next_s = R_DATA;
        end
      end
      default: begin
        r_next_s = R_IDLE;
      end
    endcase
  end

  // Read state plus registered AR/R outputs.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
    end else begin
      r_state_r <= r_next_s;
      arready_r <= (r_next_s == R_IDLE);
      rvalid_r  <= (r_next_s == R_DATA);
      if (ar_hs_s) begin
        rresp_r <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  axi4_lite_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .wr_en   (commit_s && !wr_err_s),
    .wr_idx  (word_index(wr_addr_s)),
    .wr_data (wr_data_s),
    .wr_strb (wr_strb_s),
    .rd_en   (ar_hs_s),
    .rd_idx  (word_index(s_ARADDR)),
    .rd_zero (rd_err_s),
    .rd_data (rd_data_s)
  );

  assign s_AWREADY = awready_r;
  assign s_WREADY  = wready_r;
  assign s_BVALID  = bvalid_r;
  assign s_BRESP   = bresp_r;
  assign s_ARREADY = arready_r;
  assign s_RVALID  = rvalid_r;
  assign s_RRESP   = rresp_r;
  assign s_RDATA   = rd_data_s;

endmodule
